alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-issue ALU execution unit with a valid/ready
// request port and a valid/ready result port.
//
// Handshake rules (both ports):
//   A transfer happens on a rising CLK edge where the valid and the ready
//   of that port are both 1. A producer keeps its valid and payload stable
//   until the transfer. InReady never depends on InValid, and OutValid never
//   depends on OutReady, so no combinational loop runs through the unit.
//
// Single-cycle codes register their result on the accepting edge, so
// OutValid rises one edge after acceptance. MULA runs an iterative
// shift-add multiplier in state MUL: 32 iteration edges (one multiplier bit
// per edge) followed by one accumulate edge. The accumulate edge adds the
// product into Acc, loads BusW and raises OutValid, which places the result
// 33 edges after acceptance and returns the FSM to IDLE on that same edge.
module alu_exec_unit (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [3:0]  ALUCtrl,
    input  logic [31:0] BusA,
    input  logic [31:0] BusB,
    input  logic [4:0]  Shamt,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] BusW,
    output logic        Zero,
    output logic        Overflow
);

    // Operation codes as produced by the ALU control decoder
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_MULA = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_ADDU = 4'b1000;
    localparam logic [3:0] OP_SUBU = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_LUI  = 4'b1110;

    // Counter value on the accumulate edge: 0..31 are iteration edges
    localparam logic [5:0] MUL_LAST = 6'd32;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_out_valid;
    logic [31:0] r_busw;
    logic        r_zero;
    logic        r_ovf;

    logic [31:0] r_acc;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_prod;
    logic [5:0]  r_cnt;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_is_mula;
    logic        w_mul_done;

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_alu_res;
    logic        w_alu_ovf;
    logic [31:0] w_prod_step;
    logic [31:0] w_acc_new;

    assign w_accept   = InValid & w_in_ready;
    assign w_is_mula  = (ALUCtrl == OP_MULA);
    assign w_mul_done = (r_state == S_MUL) && (r_cnt == MUL_LAST);

    assign InReady  = w_in_ready;
    assign OutValid = r_out_valid;
    assign BusW     = r_busw;
    assign Zero     = r_zero;
    assign Overflow = r_ovf;

    // Request-side ready: idle, held result leaving (or none), not in reset
    always_comb begin
        w_in_ready = 1'b0;
        if (!Reset && (r_state == S_IDLE) && (!r_out_valid || OutReady)) begin
            w_in_ready = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: enter MUL on an accepted MULA, leave on accumulate edge
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mula) begin
                    w_next_state = S_MUL;
                end
            end
            S_MUL: begin
                if (w_mul_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Single-cycle result and signed-overflow flag for the presented request
    always_comb begin
        w_sum     = BusA + BusB;
        w_diff    = BusA - BusB;
        w_alu_res = 32'h0000_0000;
        w_alu_ovf = 1'b0;
        case (ALUCtrl)
            OP_AND:  w_alu_res = BusA & BusB;
            OP_OR:   w_alu_res = BusA | BusB;
            OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (BusA[31] == BusB[31]) && (w_sum[31] != BusA[31]);
            end
            OP_SLL:  w_alu_res = BusB << Shamt;
            OP_SRL:  w_alu_res = BusB >> Shamt;
            OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (BusA[31] != BusB[31]) && (w_diff[31] != BusA[31]);
            end
            OP_SLT:  w_alu_res = {31'd0, ($signed(BusA) < $signed(BusB))};
            OP_ADDU: w_alu_res = w_sum;
            OP_SUBU: w_alu_res = w_diff;
            OP_XOR:  w_alu_res = BusA ^ BusB;
            OP_SLTU: w_alu_res = {31'd0, (BusA < BusB)};
            OP_NOR:  w_alu_res = ~(BusA | BusB);
            OP_SRA:  w_alu_res = $unsigned($signed(BusB) >>> Shamt);
            OP_LUI:  w_alu_res = {BusB[15:0], 16'h0000};
            default: begin
                // MULA goes through the iterative path; 1111 yields zero
                w_alu_res = 32'h0000_0000;
                w_alu_ovf = 1'b0;
            end
        endcase
    end

    // Shift-add step for the current multiplier bit and the final accumulate
    always_comb begin
        w_prod_step = r_prod;
        if (r_mplier[0]) begin
            w_prod_step = r_prod + r_mcand;
        end
        w_acc_new = r_acc + r_prod;
    end

    // Datapath: result hold/handoff, operand capture, multiply iteration
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_out_valid <= 1'b0;
            r_busw      <= 32'h0000_0000;
            r_zero      <= 1'b1;
            r_ovf       <= 1'b0;
            r_acc       <= 32'h0000_0000;
            r_mcand     <= 32'h0000_0000;
            r_mplier    <= 32'h0000_0000;
            r_prod      <= 32'h0000_0000;
            r_cnt       <= 6'd0;
        end else begin
            // Held result leaves on a completed output transfer
            if (r_out_valid && OutReady) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept) begin
                if (w_is_mula) begin
                    r_mcand  <= BusA;
                    r_mplier <= BusB;
                    r_prod   <= 32'h0000_0000;
                    r_cnt    <= 6'd0;
                end else begin
                    // New result replaces the departing one without a bubble
                    r_busw      <= w_alu_res;
                    r_zero      <= (w_alu_res == 32'h0000_0000);
                    r_ovf       <= w_alu_ovf;
                    r_out_valid <= 1'b1;
                end
            end

            if (r_state == S_MUL) begin
                if (w_mul_done) begin
                    r_acc       <= w_acc_new;
                    r_busw      <= w_acc_new;
                    r_zero      <= (w_acc_new == 32'h0000_0000);
                    r_ovf       <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_cnt       <= 6'd0;
                end else begin
                    r_prod   <= w_prod_step;
                    r_mcand  <= {r_mcand[30:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[31:1]};
                    r_cnt    <= r_cnt + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vectors with hand-computed results.
// Drivers change inputs 1ns after the rising edge; every observation is
// made on the falling edge.
module tb_alu_exec_unit;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_MULA = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_ADDU = 4'b1000;
    localparam logic [3:0] OP_SUBU = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_LUI  = 4'b1110;
    localparam logic [3:0] OP_ZERO = 4'b1111;

    // ---------------- clock / reset / DUT ----------------
    logic        CLK = 1'b0;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [3:0]  ALUCtrl;
    logic [31:0] BusA;
    logic [31:0] BusB;
    logic [4:0]  Shamt;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] BusW;
    logic        Zero;
    logic        Overflow;

    always #5 CLK = ~CLK;

    alu_exec_unit dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .ALUCtrl  (ALUCtrl),
        .BusA     (BusA),
        .BusB     (BusB),
        .Shamt    (Shamt),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .BusW     (BusW),
        .Zero     (Zero),
        .Overflow (Overflow)
    );

    // ---------------- scoreboard ----------------
    // Each entry packs {BusW, Zero, Overflow}
    logic [33:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [33:0] pk(input logic [31:0] w, input logic z, input logic o);
        return {w, z, o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed output transfer is checked against the queue head
    always @(negedge CLK) begin
        logic [33:0] e;
        if (Reset === 1'b0 && OutValid === 1'b1 && OutReady === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got BusW=%h Z=%b V=%b with nothing expected",
                         BusW, Zero, Overflow);
            end else begin
                e = exp_q.pop_front();
                if ({BusW, Zero, Overflow} !== e) begin
                    bad++;
                    $display("FAIL result: got BusW=%h Z=%b V=%b expected BusW=%h Z=%b V=%b",
                             BusW, Zero, Overflow, e[33:2], e[1], e[0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Present a request and hold it until accepted; returns 1ns after the accepting edge
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic push, input logic [33:0] e);
        int n;
        @(posedge CLK);
        #1;
        ALUCtrl = op;
        BusA    = a;
        BusB    = b;
        Shamt   = sh;
        InValid = 1'b1;
        if (push) exp_q.push_back(e);
        n = 0;
        @(negedge CLK);
        while (InReady !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL accept_timeout: op=%b not accepted within 100 cycles", op);
        end
        @(posedge CLK);
        #1;
        InValid = 1'b0;
    endtask

    // MULA with latency and InReady-low checks across the MUL phase
    task automatic mula_check(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int k;
        logic ir_seen;
        issue(OP_MULA, a, b, 5'd0, 1'b1, pk(exp, exp == 32'd0, 1'b0));
        k = 0;
        ir_seen = 1'b0;
        @(negedge CLK);
        while (OutValid !== 1'b1 && k < 60) begin
            if (InReady !== 1'b0) ir_seen = 1'b1;
            @(negedge CLK);
            k++;
        end
        chk("mula_latency", k, 33);
        chk("mula_inready_low", {31'd0, ir_seen}, 32'd0);
    endtask

    // Watchdog: last-resort stop if something blocks forever
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        Reset    = 1'b1;
        InValid  = 1'b0;
        ALUCtrl  = 4'd0;
        BusA     = 32'd0;
        BusB     = 32'd0;
        Shamt    = 5'd0;
        OutReady = 1'b1;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_inready",  {31'd0, InReady},  32'd0);
        chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
        chk("rst_busw",     BusW,              32'd0);
        chk("rst_zero",     {31'd0, Zero},     32'd1);
        chk("rst_ovf",      {31'd0, Overflow}, 32'd0);
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        @(negedge CLK);
        chk("rel_inready", {31'd0, InReady}, 32'd1);

        // Accumulating multiply: 0 + 3*5 = 15, then 15 + 4*4 = 31
        mula_check(32'd3, 32'd5, 32'd15);
        mula_check(32'd4, 32'd4, 32'd31);

        // Directed single-cycle vectors
        issue(OP_ADD,  32'h7FFF_FFFF, 32'h1,         5'd0,  1'b1, pk(32'h8000_0000, 1'b0, 1'b1));
        issue(OP_ADDU, 32'h7FFF_FFFF, 32'h1,         5'd0,  1'b1, pk(32'h8000_0000, 1'b0, 1'b0));
        issue(OP_SUB,  32'h8000_0000, 32'h1,         5'd0,  1'b1, pk(32'h7FFF_FFFF, 1'b0, 1'b1));
        issue(OP_SUBU, 32'h8000_0000, 32'h1,         5'd0,  1'b1, pk(32'h7FFF_FFFF, 1'b0, 1'b0));
        issue(OP_SRA,  32'h0,         32'h8000_0000, 5'd4,  1'b1, pk(32'hF800_0000, 1'b0, 1'b0));
        issue(OP_SRL,  32'h0,         32'h8000_0000, 5'd4,  1'b1, pk(32'h0800_0000, 1'b0, 1'b0));
        issue(OP_SLL,  32'h0,         32'h1,         5'd31, 1'b1, pk(32'h8000_0000, 1'b0, 1'b0));
        issue(OP_LUI,  32'h0,         32'hABCD_1234, 5'd0,  1'b1, pk(32'h1234_0000, 1'b0, 1'b0));
        issue(OP_SLT,  32'hFFFF_FFFF, 32'h1,         5'd0,  1'b1, pk(32'h0000_0001, 1'b0, 1'b0));
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1,         5'd0,  1'b1, pk(32'h0000_0000, 1'b1, 1'b0));
        issue(OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  1'b1, pk(32'h00F0_00F0, 1'b0, 1'b0));
        issue(OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 5'd0,  1'b1, pk(32'hFFFF_F0F0, 1'b0, 1'b0));
        issue(OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0,  1'b1, pk(32'hF0F0_0F0F, 1'b0, 1'b0));
        issue(OP_NOR,  32'h0,         32'h0,         5'd0,  1'b1, pk(32'hFFFF_FFFF, 1'b0, 1'b0));
        issue(OP_ZERO, 32'h7FFF_FFFF, 32'h1,         5'd0,  1'b1, pk(32'h0000_0000, 1'b1, 1'b0));

        // Stalled consumer: SUB 5-5 held for 5 cycles, then back-to-back ADD
        repeat (3) @(posedge CLK);
        #1;
        OutReady = 1'b0;
        issue(OP_SUB, 32'd5, 32'd5, 5'd0, 1'b1, pk(32'h0, 1'b1, 1'b0));
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("stall_outvalid", {31'd0, OutValid}, 32'd1);
            chk("stall_busw",     BusW,              32'd0);
            chk("stall_zero",     {31'd0, Zero},     32'd1);
            chk("stall_inready",  {31'd0, InReady},  32'd0);
        end
        @(posedge CLK);
        #1;
        OutReady = 1'b1;
        ALUCtrl  = OP_ADD;
        BusA     = 32'd2;
        BusB     = 32'd3;
        Shamt    = 5'd0;
        InValid  = 1'b1;
        exp_q.push_back(pk(32'd5, 1'b0, 1'b0));
        @(negedge CLK);
        chk("b2b_inready", {31'd0, InReady}, 32'd1);
        @(posedge CLK);
        #1;
        InValid = 1'b0;
        @(negedge CLK);
        chk("b2b_no_bubble", {31'd0, OutValid}, 32'd1);

        // Reset in the middle of a MULA: result discarded, Acc cleared
        repeat (2) @(posedge CLK);
        issue(OP_MULA, 32'd7, 32'd9, 5'd0, 1'b0, 34'd0);
        repeat (10) @(posedge CLK);
        #1;
        Reset = 1'b1;
        @(negedge CLK);
        chk("midrst_inready_during", {31'd0, InReady}, 32'd0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("midrst_outvalid", {31'd0, OutValid}, 32'd0);
        chk("midrst_inready",  {31'd0, InReady},  32'd0);
        chk("midrst_busw",     BusW,              32'd0);
        chk("midrst_zero",     {31'd0, Zero},     32'd1);
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        @(negedge CLK);
        chk("midrst_rel_inready", {31'd0, InReady}, 32'd1);
        mula_check(32'd2, 32'd2, 32'd4);

        // Drain and confirm every expected result was seen
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
